// File: rtl/data_sram_slave_if.sv
//------------------------------------------------------------------------------
// Module  : data_sram_slave_if
// Purpose : Data-SRAM style request/response bus between a CPU-side master
//           and the data_sram_slave memory/register block.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_sram_slave_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/data_sram_slave.sv
//------------------------------------------------------------------------------
// Module  : data_sram_slave
// Purpose : Word-addressed on-chip RAM plus a small register window
//           (LED, SWITCH, TIMER, SCRATCH) at 0xbfaf_xxxx. Registered,
//           read-first read data with one cycle of latency.
// Options : define DATA_SRAM_TIMER_EN to build the free-running TIMER
//           register at offset 0xf008; otherwise that offset reads 0.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_sram_slave #(
    parameter int RAM_AW = 10
) (
    input  wire logic           clk,
    input  wire logic           resetn,
    data_sram_slave_if.slave    bus,
    input  wire logic [7:0]     switch,
    output logic      [15:0]    led
);

    localparam int          c_RAM_DEPTH  = 1 << RAM_AW;
    localparam logic [15:0] c_REG_BASE   = 16'hbfaf;
    localparam logic [15:0] c_OFF_LED    = 16'hf000;
    localparam logic [15:0] c_OFF_SWITCH = 16'hf004;
    localparam logic [15:0] c_OFF_TIMER  = 16'hf008;
    localparam logic [15:0] c_OFF_SCR    = 16'hf00c;

    // Byte-lane merge of new write data into an existing word.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]       r_mem [0:c_RAM_DEPTH-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_scratch;
    logic [31:0]       w_timer_rd;
    logic [31:0]       w_rd_data;

    logic              w_req;
    logic              w_wr;
    logic              w_is_reg;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [13:0]       w_off;
    logic              w_sel_led;
    logic              w_sel_switch;
    logic              w_sel_timer;
    logic              w_sel_scr;
    logic [1:0]        w_unused_addr;

    assign w_req         = bus.data_sram_en;
    assign w_wr          = w_req && (bus.data_sram_wen != 4'h0);
    assign w_is_reg      = (bus.data_sram_addr[31:16] == c_REG_BASE);
    assign w_ram_idx     = bus.data_sram_addr[RAM_AW+1:2];
    assign w_off         = bus.data_sram_addr[15:2];
    assign w_unused_addr = bus.data_sram_addr[1:0];

    assign w_sel_led     = w_is_reg && (w_off == c_OFF_LED[15:2]);
    assign w_sel_switch  = w_is_reg && (w_off == c_OFF_SWITCH[15:2]);
    assign w_sel_timer   = w_is_reg && (w_off == c_OFF_TIMER[15:2]);
    assign w_sel_scr     = w_is_reg && (w_off == c_OFF_SCR[15:2]);

    // RAM byte-lane writes; contents survive reset, but a write presented
    // while reset is asserted is dropped.
    always_ff @(posedge clk) begin
        if (resetn && w_wr && !w_is_reg) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    r_mem[w_ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // LED register: only the low two byte lanes exist.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_led <= 16'h0;
        end else if (w_wr && w_sel_led) begin
            if (bus.data_sram_wen[0]) r_led[7:0]  <= bus.data_sram_wdata[7:0];
            if (bus.data_sram_wen[1]) r_led[15:8] <= bus.data_sram_wdata[15:8];
        end
    end

    // SCRATCH register: plain 32-bit read/write storage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_scratch <= 32'h0;
        end else if (w_wr && w_sel_scr) begin
            r_scratch <= f_merge(r_scratch, bus.data_sram_wdata, bus.data_sram_wen);
        end
    end

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] r_timer;

    // Free-running timer; a bus write wins over the increment for that cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_timer <= 32'h0;
        end else if (w_wr && w_sel_timer) begin
            r_timer <= f_merge(r_timer, bus.data_sram_wdata, bus.data_sram_wen);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer_rd = r_timer;
`else
    assign w_timer_rd = 32'h0;
`endif

    // Read mux: current (pre-write) value of the addressed target.
    always_comb begin
        w_rd_data = 32'h0;
        if (w_is_reg) begin
            if (w_sel_led) begin
                w_rd_data = {16'h0, r_led};
            end else if (w_sel_switch) begin
                w_rd_data = {24'h0, switch};
            end else if (w_sel_timer) begin
                w_rd_data = w_timer_rd;
            end else if (w_sel_scr) begin
                w_rd_data = r_scratch;
            end
        end else begin
            w_rd_data = r_mem[w_ram_idx];
        end
    end

    // Registered read data, updated on every accepted request and held otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata <= 32'h0;
        end else if (w_req) begin
            r_rdata <= w_rd_data;
        end
    end

    assign bus.data_sram_rdata = r_rdata;
    assign led                 = r_led;

endmodule

`default_nettype wire

// File: tb/tb_data_sram_slave.sv
//------------------------------------------------------------------------------
// Module  : tb_data_sram_slave
// Purpose : Self-checking bench for data_sram_slave: directed vectors with
//           literal expectations plus a cycle-accurate reference model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_sram_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  switch;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    data_sram_slave_if bus ();

    data_sram_slave #(.RAM_AW(10)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .switch (switch),
        .led    (led)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_mem   [0:1023];
    logic [3:0]  m_known [0:1023];
    logic [31:0] m_rdata;
    bit          m_rknown = 1'b0;
    logic [15:0] m_led;
    bit          m_led_known = 1'b0;
    logic [31:0] m_scratch;
    logic [31:0] m_timer;

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 4'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] a, rv, pre_t;
        logic [15:0] off;
        int          idx;
        bit          rk;
        if (!resetn) begin
            m_rdata = 0; m_rknown = 1; m_led = 0; m_led_known = 1;
            m_scratch = 0; m_timer = 0;
        end else begin
            pre_t = m_timer;
            m_timer = m_timer + 1;
            if (bus.data_sram_en) begin
                a   = bus.data_sram_addr;
                off = a[15:0] & 16'hfffc;
                idx = int'((a >> 2) % 1024);
                rv  = 0;
                rk  = 1;
                if (a[31:16] == 16'hbfaf) begin
                    case (off)
                        16'hf000: rv = {16'h0, m_led};
                        16'hf004: rv = {24'h0, switch};
`ifdef DATA_SRAM_TIMER_EN
                        16'hf008: rv = pre_t;
`endif
                        16'hf00c: rv = m_scratch;
                        default:  rv = 0;
                    endcase
                end else begin
                    rv = m_mem[idx];
                    rk = (m_known[idx] == 4'hf);
                end
                m_rdata  = rv;
                m_rknown = rk;
                for (int b = 0; b < 4; b++) begin
                    if (bus.data_sram_wen[b]) begin
                        if (a[31:16] != 16'hbfaf) begin
                            m_mem[idx][8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                            m_known[idx][b] = 1'b1;
                        end else if (off == 16'hf000 && b < 2) begin
                            m_led[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                        end else if (off == 16'hf00c) begin
                            m_scratch[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                        end else if (off == 16'hf008) begin
                            m_timer[8*b +: 8] = bus.data_sram_wdata[8*b +: 8];
                        end
                    end
                end
                // a timer write replaces the increment entirely
                if (a[31:16] == 16'hbfaf && off == 16'hf008 && bus.data_sram_wen != 0) begin
                    for (int b = 0; b < 4; b++)
                        if (!bus.data_sram_wen[b]) m_timer[8*b +: 8] = pre_t[8*b +: 8];
                end
            end
        end
    end

    // Compare process: outputs are stable around the falling edge.
    always @(negedge clk) begin
        if (m_rknown)    chk("model_rdata", bus.data_sram_rdata, m_rdata);
        if (m_led_known) chk("model_led", {16'h0, led}, {16'h0, m_led});
    end

    // ---------------- stimulus ----------------
    task automatic op(input bit rst_n, input bit en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        resetn              = rst_n;
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr);
        op(1'b1, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] d);
        op(1'b1, 1'b1, wen, addr, d);
    endtask

    task automatic idle();
        op(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] addrs [0:7];
        resetn = 1'b0;
        switch = 8'h00;
        bus.data_sram_en = 0; bus.data_sram_wen = 0;
        bus.data_sram_addr = 0; bus.data_sram_wdata = 0;

        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        op(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("reset_rdata", bus.data_sram_rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);

        // full-word RAM write then read-back
        wr(32'h1c000100, 4'hf, 32'h12345678);
        rd(32'h1c000100);
        chk("ram_full_rd", bus.data_sram_rdata, 32'h12345678);

        // partial write: rdata shows the pre-write word
        wr(32'h1c000100, 4'b0010, 32'h0000ab00);
        chk("ram_readfirst", bus.data_sram_rdata, 32'h12345678);
        rd(32'h1c000100);
        chk("ram_partial_rd", bus.data_sram_rdata, 32'h1234ab78);

        // alias of upper address bits
        rd(32'h00001100);
        chk("ram_alias_rd", bus.data_sram_rdata, 32'h1234ab78);

        // LED register
        wr(32'hbfaff000, 4'hf, 32'hffff5a5a);
        chk("led_after_wr", {16'h0, led}, 32'h00005a5a);
        rd(32'hbfaff000);
        chk("led_rd", bus.data_sram_rdata, 32'h00005a5a);

        // TIMER wrap: fffffffe -> ffffffff -> 0, read sampled pre-increment
        wr(32'hbfaff008, 4'hf, 32'hfffffffe);
        idle();
        idle();
        rd(32'hbfaff008);
        chk("timer_wrap", bus.data_sram_rdata, 32'h0);

        // switch and unmapped offsets
        switch = 8'hc3;
        rd(32'hbfaff004);
        chk("switch_rd", bus.data_sram_rdata, 32'h000000c3);
        wr(32'hbfaff010, 4'hf, 32'hcafef00d);
        rd(32'hbfaff010);
        chk("unmapped_rd", bus.data_sram_rdata, 32'h0);

        // SCRATCH with byte lanes
        wr(32'hbfaff00c, 4'hf, 32'hdeadbeef);
        wr(32'hbfaff00c, 4'b1001, 32'h11223344);
        chk("scr_readfirst", bus.data_sram_rdata, 32'hdeadbeef);
        rd(32'hbfaff00c);
        chk("scr_partial_rd", bus.data_sram_rdata, 32'h11adbe44);

        // en=0: nothing written, rdata held
        op(1'b1, 1'b0, 4'hf, 32'h1c000100, 32'hffffffff);
        chk("en0_hold", bus.data_sram_rdata, 32'h11adbe44);
        rd(32'h1c000100);
        chk("en0_nowrite", bus.data_sram_rdata, 32'h1234ab78);

        // reset concurrent with a SCRATCH write
        op(1'b0, 1'b1, 4'hf, 32'hbfaff00c, 32'h00000055);
        chk("rst_rdata", bus.data_sram_rdata, 32'h0);
        rd(32'hbfaff00c);
        chk("rst_scr", bus.data_sram_rdata, 32'h0);
        rd(32'h1c000100);
        chk("rst_ram_kept", bus.data_sram_rdata, 32'h1234ab78);

        // mixed traffic checked by the model
        addrs[0] = 32'h1c000100; addrs[1] = 32'h1c000104; addrs[2] = 32'hbfaff000;
        addrs[3] = 32'hbfaff004; addrs[4] = 32'hbfaff008; addrs[5] = 32'hbfaff00c;
        addrs[6] = 32'hbfaff010; addrs[7] = 32'h00001104;
        for (int k = 0; k < 60; k++) begin
            switch = 8'($urandom);
            op(1'b1, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
               addrs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
               $urandom);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_sram_slave.md
DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 Parameter: RAM_AW, 10, RAM word-address width; RAM depth is 2^RAM_AW 32-bit words.
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: resetn  input  1  reset, synchronous, active-low.
REQ-004 Port: data_sram_en  input  1  access request this cycle.
REQ-005 Port: data_sram_wen  input  4  byte write enables; lane i covers wdata[8i+7:8i]; 4'h0 means read.
REQ-006 Port: data_sram_addr  input  32  byte address; bits [1:0] ignored.
REQ-007 Port: data_sram_wdata  input  32  write data.
REQ-008 Port: data_sram_rdata  output  32  read data, registered.
REQ-009 Port: switch  input  8  external switch levels, readable via register.
REQ-010 Port: led  output  16  LED register value.

Function
REQ-011 Address decode: addr[31:16]==16'hbfaf -> register space; all other addresses -> RAM at word index addr[RAM_AW+1:2], upper bits aliased.
REQ-012 Register map (offset addr[15:0]): 0xf000 LED (RW, low 16 bits), 0xf004 SWITCH (RO, zero-extended), 0xf008 TIMER (RW), 0xf00c SCRATCH (RW); other offsets read 0, writes ignored.
REQ-013 Write: on a cycle with en=1 and wen!=0, only enabled byte lanes of the target are updated at that posedge; other lanes unchanged.
REQ-014 Read latency: on a cycle with en=1, data_sram_rdata shows the addressed word from the next posedge onward.
REQ-015 en=0: data_sram_rdata holds its previous value; no state besides TIMER changes.
REQ-016 Write cycle (en=1, wen!=0): data_sram_rdata is loaded with the target's pre-write value (read-first).
REQ-017 Read of a location written in the immediately preceding cycle returns the newly written value.
REQ-018 TIMER increments by 1 every cycle out of reset; wraps 32'hffffffff -> 32'h0.
REQ-019 TIMER write has priority over increment: the written (byte-merged) value is loaded that posedge; incrementing resumes from it the next cycle.
REQ-020 TIMER read returns the value held at the posedge of the request cycle (pre-increment).
REQ-021 SWITCH is sampled into rdata directly at the request posedge; no synchronizer in this block.
REQ-022 led is driven combinationally from the LED register; LED bits [31:16] read as 0.

Reset
REQ-023 While resetn=0 at a posedge: data_sram_rdata=0, LED=0, TIMER=0, SCRATCH=0; requests in that cycle are discarded.
REQ-024 RAM contents are not reset and are retained across reset.
REQ-025 Reset asserted mid-operation discards any write presented in the same cycle; first post-reset cycle accepts requests normally.

Configuration
REQ-026 Macro DATA_SRAM_TIMER_EN defined: TIMER implemented per REQ-018..020.
REQ-027 DATA_SRAM_TIMER_EN undefined: no TIMER register; offset 0xf008 reads 0, writes ignored.

Verification
REQ-028 Write RAM 0x1c000100 data 0x12345678 wen=4'hf, next cycle read same -> rdata=0x12345678 one cycle after read request.
REQ-029 Then write wen=4'b0010 data 0x0000ab00, read -> rdata=0x1234ab78; rdata during write cycle result = 0x12345678.
REQ-030 Write LED 0xbfaff000 data 0xffff5a5a -> led=16'h5a5a next cycle; read -> rdata=0x00005a5a.
REQ-031 Write TIMER 0xfffffffe, read two cycles later -> rdata=0x00000000 (wrap); without DATA_SRAM_TIMER_EN -> 0.
REQ-032 switch=8'hc3, read 0xbfaff004 -> rdata=0x000000c3; read 0xbfaff010 -> rdata=0.
REQ-033 Assert resetn=0 for one cycle concurrent with a SCRATCH write of 0x55 -> SCRATCH reads 0, rdata=0, RAM word from REQ-028 still reads 0x1234ab78.
